// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, one bit-period counter,
// mid-bit sampling, held output byte with valid/overrun handshake.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s to fall
// START  | timing to mid start bit to confirm it is not a glitch
// DATA   | sampling 8 data bits, LSB first, one per bit period
// STOP   | sampling the stop bit; high delivers the byte, low is a framing error
// BREAK  | stop bit was low; wait for the line to return high before re-arming
module uart_rx_core #(
  parameter int clk_rate  = 50000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int P  = clk_rate / baud_rate;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(P - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(P / 2 - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          stop_sample;
  logic          good_frame;
  logic          bad_frame;
  logic          ack_taken;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign stop_sample = (state == ST_STOP) && (cnt == CNT_FULL);
  assign good_frame  = stop_sample && rx_s;
  assign bad_frame   = stop_sample && !rx_s;
  assign ack_taken   = rx_ack && rx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            // Returning to IDLE mid-stop-bit leaves half a bit of slack for
            // the next start edge.
            state <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A byte landing together with an acknowledge replaces the old one cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      if (good_frame) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
        if (ack_taken)     overrun <= 1'b0;
        else if (rx_valid) overrun <= 1'b1;
      end else if (ack_taken) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at P=10 clocks per bit.
module tb_uart_rx_core;

  localparam int P = 10;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_errors = 0;
  int fe_count = 0;

  uart_rx_core #(.clk_rate(1000000), .baud_rate(100000)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst && frame_err) fe_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; each held P clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (P) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!rx_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    int fe0;
    logic saw_busy;

    rst = 1'b0; rx_in = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ovr",   overrun, 1'b0);
    check("rst_ferr",  frame_err, 1'b0);
    check("rst_busy",  rx_busy, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame and latency bound
    fe0 = fe_count;
    fork
      send_frame(8'h55, 1'b1);
      wait_valid(120, cyc);
    join
    check("f55_valid", rx_valid, 1'b1);
    check("f55_latency_ok", (cyc <= 99), 1'b1);
    check("f55_data", rx_data, 8'h55);
    check("f55_noferr", fe_count - fe0, 0);
    check("f55_idle", rx_busy, 1'b0);
    pulse_ack();
    check("f55_ack_valid", rx_valid, 1'b0);
    repeat (5) @(negedge clk);

    // Three-clock glitch
    saw_busy = 1'b0;
    fe0 = fe_count;
    rx_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    rx_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    check("glitch_start_seen", saw_busy, 1'b1);
    check("glitch_idle", rx_busy, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_noferr", fe_count - fe0, 0);

    // Framing error then break
    fe0 = fe_count;
    send_frame(8'hA3, 1'b0);
    repeat (30) @(negedge clk);
    check("ferr_pulses", fe_count - fe0, 1);
    check("ferr_valid", rx_valid, 1'b0);
    check("ferr_data_kept", rx_data, 8'h55);
    check("ferr_break_busy", rx_busy, 1'b1);
    rx_in = 1'b1;
    repeat (2 * P) @(negedge clk);
    check("break_exit_idle", rx_busy, 1'b0);
    fork
      send_frame(8'h0F, 1'b1);
      wait_valid(120, cyc);
    join
    check("f0f_valid", rx_valid, 1'b1);
    check("f0f_data", rx_data, 8'h0F);
    pulse_ack();
    repeat (5) @(negedge clk);

    // Back-to-back frames, no ack
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check("b2b_data", rx_data, 8'h34);
    check("b2b_valid", rx_valid, 1'b1);
    check("b2b_ovr", overrun, 1'b1);
    pulse_ack();
    check("b2b_ack_valid", rx_valid, 1'b0);
    check("b2b_ack_ovr", overrun, 1'b0);
    repeat (5) @(negedge clk);

    // Ack coincident with completion of 0x77 while 0x12 pending
    send_frame(8'h12, 1'b1);
    check("pend_valid", rx_valid, 1'b1);
    check("pend_ovr", overrun, 1'b0);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (97) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    check("coinc_data", rx_data, 8'h77);
    check("coinc_valid", rx_valid, 1'b1);
    check("coinc_ovr", overrun, 1'b0);
    pulse_ack();
    check("coinc_ack_valid", rx_valid, 1'b0);
    repeat (5) @(negedge clk);

    // Reset during data bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (54) @(negedge clk);
        check("pre_rst_busy", rx_busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_busy", rx_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (2 * P) @(negedge clk);
    check("post_rst_valid", rx_valid, 1'b0);
    check("post_rst_busy", rx_busy, 1'b0);
    fork
      send_frame(8'h81, 1'b1);
      wait_valid(120, cyc);
    join
    check("f81_valid", rx_valid, 1'b1);
    check("f81_data", rx_data, 8'h81);
    check("f81_ovr", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter clk_rate, default 50000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, serial bit rate; bit period P = clk_rate/baud_rate clocks (integer division), P >= 4 required.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx_in  input  1  asynchronous serial line, idle high; 8N1 frames, LSB first.
REQ-006 rx_ack  input  1  consumer acknowledge; clears rx_valid/overrun.
REQ-007 rx_data  output  8  last correctly framed byte.
REQ-008 rx_valid  output  1  level; byte in rx_data not yet acknowledged.
REQ-009 overrun  output  1  sticky; byte completed while rx_valid already high.
REQ-010 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop output rx_s.
REQ-013 FSM states: IDLE, START, DATA, STOP, BREAK; single bit-period counter, width $clog2(P), plus 3-bit bit index.
REQ-014 IDLE: rx_s==0 -> START, counter cleared.
REQ-015 START: at counter == P/2-1 sample rx_s; 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no output change).
REQ-016 DATA: at counter == P-1 sample rx_s into shift register MSB, shifting right (LSB-first), counter cleared, bit index incremented; after bit index 7 -> STOP.
REQ-017 STOP: at counter == P-1 sample rx_s; 1 -> good frame; 0 -> frame_err pulse, byte discarded, -> BREAK.
REQ-018 Good frame: next clock rx_data <= shift register, rx_valid <= 1, FSM -> IDLE (mid-stop-bit, allowing back-to-back frames).
REQ-019 BREAK: remain until rx_s==1, then -> IDLE; no new start detected while line held low.
REQ-020 rx_ack sampled high with rx_valid high SHALL clear rx_valid and overrun next clock; rx_ack with rx_valid low is ignored.
REQ-021 Good frame completing while rx_valid==1 and rx_ack==0: rx_data overwritten, rx_valid stays 1, overrun <= 1.
REQ-022 Good frame completing in the same cycle as rx_ack: new byte wins; rx_data updated, rx_valid stays 1, overrun <= 0.
REQ-023 frame_err does not alter rx_data, rx_valid or overrun.
REQ-024 Counter SHALL never exceed P-1; it wraps to 0 only on a sample event or state change.

Reset
REQ-025 On rst low, immediately: FSM IDLE, counter/bit index/shift register 0, synchronizer flops 1, rx_data 0x00, rx_valid 0, overrun 0, frame_err 0, rx_busy 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no output; after release, reception resumes only on a new falling edge seen in IDLE.

Verification (clk_rate=1000000, baud_rate=100000, P=10)
REQ-027 Frame 0x55 with stop=1 -> rx_data=0x55, rx_valid=1 within 9.5*P+4 clocks of the start edge, frame_err never pulses.
REQ-028 Low glitch of 3 clocks on idle line -> START entered, returns to IDLE at mid-sample; rx_valid, frame_err stay 0.
REQ-029 Frame 0xA3 with stop=0, line held low 30 clocks -> single frame_err pulse, rx_valid stays 0, FSM in BREAK until line high, then 0x0F frame received correctly.
REQ-030 Frames 0x12 then 0x34 back-to-back, no rx_ack -> rx_data=0x34, rx_valid=1, overrun=1; rx_ack pulse -> both cleared next clock.
REQ-031 rx_ack asserted in the exact cycle 0x77 completes with 0x12 pending -> rx_data=0x77, rx_valid=1, overrun=0.
REQ-032 rst pulsed low during DATA bit 4 of 0xFF -> all outputs at reset values, no byte delivered; next frame 0x81 received correctly.
